vend_coin_payer: RTL and testbench

//  Customer-side initiator for the vending-machine coin interface. On a start

---
 rtl/vend_coin_payer.sv | 217 +++++++++++++++++++++
 tb/tb_vend_coin_payer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/vend_coin_payer.sv
// -----------------------------------------------------------------------------
// vend_coin_payer
//   Customer-side initiator for the vending-machine coin interface. When a
//   start request is accepted it sends the programmed numbers of one-yuan and
//   half-yuan coins as single-cycle pulses, separated by GAP_CYC idle cycles.
//   It then waits up to TIMEOUT_CYC cycles for a beverage pulse. Change pulses
//   from the machine are accumulated. The block reports:
//     - the paid total,
//     - the change received,
//     - the coins left unsent because the beverage arrived early,
//     - whether the transaction ended with a beverage or a timeout.
//
// Ports
//   sys_clk, sys_rst_n       clock (rising edge), asynchronous active-low reset
//   start                    request pulse, honoured only when idle
//   half_first               1: half coins before one coins, 0: ones first
//   num_one, num_half        coin counts, latched when start is accepted
//   po_coin_one/half         registered coin pulses towards the machine
//   pi_beverage              beverage pulse from the machine
//   pi_change_one/half       change pulses from the machine
//   busy                     transaction in progress (low in the done cycle)
//   done                     one-cycle completion pulse
//   ok, timeout              outcome, held until the next accepted start
//   paid_units               half-yuan units sent, held
//   change_units             half-yuan units of change received, held
//   unsent_one/half          coins not sent because of an early beverage, held
// -----------------------------------------------------------------------------
module vend_coin_payer #(
    parameter int GAP_CYC     = 2,
    parameter int TIMEOUT_CYC = 8,
    parameter int CNT_W       = 3
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             start,
    input  logic             half_first,
    input  logic [CNT_W-1:0] num_one,
    input  logic [CNT_W-1:0] num_half,
    output logic             po_coin_one,
    output logic             po_coin_half,
    input  logic             pi_beverage,
    input  logic             pi_change_one,
    input  logic             pi_change_half,
    output logic             busy,
    output logic             done,
    output logic             ok,
    output logic             timeout,
    output logic [CNT_W+1:0] paid_units,
    output logic [2:0]       change_units,
    output logic [CNT_W-1:0] unsent_one,
    output logic [CNT_W-1:0] unsent_half
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEND = 3'd1,
        S_GAP  = 3'd2,
        S_WAIT = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    localparam int GAP_W = $clog2(GAP_CYC + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] rem_one, rem_half;
    logic             hf_q;
    logic [GAP_W-1:0] gap_cnt;
    logic [TMO_W-1:0] tmo_cnt;

    logic             accept, active, fire, pick_half;
    logic [CNT_W-1:0] base_one, base_half;
    logic             base_hf;
    logic [CNT_W-1:0] rem_one_nxt, rem_half_nxt;
    logic [GAP_W-1:0] gap_cnt_nxt;
    logic [TMO_W-1:0] tmo_cnt_nxt;
    logic             coin_one_nxt, coin_half_nxt, busy_nxt, done_nxt;
    logic             ok_nxt, timeout_nxt;
    logic [CNT_W+1:0] paid_nxt;
    logic [2:0]       change_nxt;
    logic [CNT_W-1:0] unsent_one_nxt, unsent_half_nxt;

    // Saturating adders for the accumulated totals.
    function automatic logic [CNT_W+1:0] sat_paid(input logic [CNT_W+1:0] a,
                                                  input logic [1:0]       inc);
        logic [CNT_W+2:0] s;
        s = {1'b0, a} + {{(CNT_W+1){1'b0}}, inc};
        return s[CNT_W+2] ? {(CNT_W+2){1'b1}} : s[CNT_W+1:0];
    endfunction

    function automatic logic [2:0] sat_chg(input logic [2:0] a,
                                           input logic [1:0] inc);
        logic [3:0] s;
        s = {1'b0, a} + {2'b00, inc};
        return s[3] ? 3'b111 : s[2:0];
    endfunction

    // State register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= S_IDLE;
        else            state <= state_nxt;
    end

    // Next-state logic. The beverage takes priority over every other exit,
    // so a beverage in the last wait cycle still counts as success.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start)
                        state_nxt = (num_one == '0 && num_half == '0) ? S_FIN : S_SEND;
            S_SEND: if (pi_beverage)                        state_nxt = S_FIN;
                    else if (rem_one == '0 && rem_half == '0) state_nxt = S_WAIT;
                    else                                     state_nxt = S_GAP;
            S_GAP:  if (pi_beverage)             state_nxt = S_FIN;
                    else if (gap_cnt == GAP_LAST) state_nxt = S_SEND;
            S_WAIT: if (pi_beverage)             state_nxt = S_FIN;
                    else if (tmo_cnt == TMO_LAST) state_nxt = S_FIN;
            S_FIN:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output / datapath next values. Every output is a flop loaded from
    // these, so a coin pulse is decided one cycle ahead, on the edge
    // that enters SEND.
    always_comb begin
        accept    = (state == S_IDLE) && start;
        active    = (state == S_SEND) || (state == S_GAP) || (state == S_WAIT);
        base_one  = accept ? num_one    : rem_one;
        base_half = accept ? num_half   : rem_half;
        base_hf   = accept ? half_first : hf_q;
        fire      = (state_nxt == S_SEND);
        // When ones go first, a half is picked only after the ones run out.
        pick_half = base_hf ? (base_half != '0) : (base_one == '0);

        rem_one_nxt   = base_one;
        rem_half_nxt  = base_half;
        coin_one_nxt  = 1'b0;
        coin_half_nxt = 1'b0;
        paid_nxt      = accept ? '0 : paid_units;
        if (fire) begin
            if (pick_half) begin
                coin_half_nxt = 1'b1;
                rem_half_nxt  = base_half - CNT_W'(1);
                paid_nxt      = sat_paid(paid_nxt, 2'd1);
            end else begin
                coin_one_nxt  = 1'b1;
                rem_one_nxt   = base_one - CNT_W'(1);
                paid_nxt      = sat_paid(paid_nxt, 2'd2);
            end
        end

        change_nxt = accept ? 3'd0 : change_units;
        if (state != S_IDLE) begin
            if (pi_change_one)  change_nxt = sat_chg(change_nxt, 2'd2);
            if (pi_change_half) change_nxt = sat_chg(change_nxt, 2'd1);
        end

        ok_nxt          = accept ? 1'b0 : ok;
        timeout_nxt     = accept ? 1'b0 : timeout;
        unsent_one_nxt  = accept ? '0 : unsent_one;
        unsent_half_nxt = accept ? '0 : unsent_half;
        if (active && pi_beverage) begin
            ok_nxt          = 1'b1;
            unsent_one_nxt  = rem_one;
            unsent_half_nxt = rem_half;
        end
        if (state == S_WAIT && !pi_beverage && tmo_cnt == TMO_LAST)
            timeout_nxt = 1'b1;

        gap_cnt_nxt = (state == S_GAP  && state_nxt == S_GAP)  ? gap_cnt + GAP_W'(1) : '0;
        tmo_cnt_nxt = (state == S_WAIT && state_nxt == S_WAIT) ? tmo_cnt + TMO_W'(1) : '0;

        busy_nxt = (state_nxt == S_SEND) || (state_nxt == S_GAP) || (state_nxt == S_WAIT);
        done_nxt = (state_nxt == S_FIN);
    end

    // Registered outputs and working counters
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rem_one      <= '0;
            rem_half     <= '0;
            hf_q         <= 1'b0;
            gap_cnt      <= '0;
            tmo_cnt      <= '0;
            po_coin_one  <= 1'b0;
            po_coin_half <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            ok           <= 1'b0;
            timeout      <= 1'b0;
            paid_units   <= '0;
            change_units <= '0;
            unsent_one   <= '0;
            unsent_half  <= '0;
        end else begin
            rem_one      <= rem_one_nxt;
            rem_half     <= rem_half_nxt;
            hf_q         <= base_hf;
            gap_cnt      <= gap_cnt_nxt;
            tmo_cnt      <= tmo_cnt_nxt;
            po_coin_one  <= coin_one_nxt;
            po_coin_half <= coin_half_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            ok           <= ok_nxt;
            timeout      <= timeout_nxt;
            paid_units   <= paid_nxt;
            change_units <= change_nxt;
            unsent_one   <= unsent_one_nxt;
            unsent_half  <= unsent_half_nxt;
        end
    end

endmodule

// File: tb/tb_vend_coin_payer.sv
module tb_vend_coin_payer;

    localparam int GAP = 2;
    localparam int TMO = 8;
    localparam int CW  = 3;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          start = 1'b0;
    logic          half_first = 1'b0;
    logic [CW-1:0] num_one = '0;
    logic [CW-1:0] num_half = '0;
    logic          po_coin_one, po_coin_half;
    logic          pi_beverage = 1'b0;
    logic          pi_change_one = 1'b0;
    logic          pi_change_half = 1'b0;
    logic          busy, done, ok, timeout;
    logic [CW+1:0] paid_units;
    logic [2:0]    change_units;
    logic [CW-1:0] unsent_one, unsent_half;

    vend_coin_payer #(.GAP_CYC(GAP), .TIMEOUT_CYC(TMO), .CNT_W(CW)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start),
        .half_first(half_first), .num_one(num_one), .num_half(num_half),
        .po_coin_one(po_coin_one), .po_coin_half(po_coin_half),
        .pi_beverage(pi_beverage), .pi_change_one(pi_change_one),
        .pi_change_half(pi_change_half), .busy(busy), .done(done), .ok(ok),
        .timeout(timeout), .paid_units(paid_units), .change_units(change_units),
        .unsent_one(unsent_one), .unsent_half(unsent_half)
    );

    always #5 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit          hf;
        logic [2:0]  n1;
        logic [2:0]  nh;
        int          bev;   // cycle of beverage pulse, 0 = machine silent
        logic [63:0] m1;    // change_one pulse per cycle
        logic [63:0] mh;    // change_half pulse per cycle
        int          rs;    // cycle of an extra start while busy, 0 = none
        logic [15:0] exp;   // {ok, timeout, paid[4:0], change[2:0], unsent_one, unsent_half}
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mk(input bit o, input bit t, input int p, input int c,
                                       input int u1, input int uh);
        return {o, t, 5'(p), 3'(c), 3'(u1), 3'(uh)};
    endfunction

    function automatic logic [15:0] dut_res();
        return {ok, timeout, paid_units, change_units, unsent_one, unsent_half};
    endfunction

    function automatic logic [19:0] all_outs();
        return {po_coin_one, po_coin_half, busy, done, dut_res()};
    endfunction

    // Reference model: coin k goes out in cycle 1 + k*(GAP+1); everything
    // else follows from where the beverage falls relative to that schedule.
    task automatic model(input bit hf, input logic [2:0] n1, input logic [2:0] nh,
                         input int bev, input logic [63:0] m1, input logic [63:0] mh,
                         output int done_c, output logic [15:0] r,
                         output logic [63:0] e1, output logic [63:0] eh);
        int n, sent, last, s1, sh, paid, chg;
        bit o, t;
        n = int'(n1) + int'(nh);
        e1 = '0; eh = '0; s1 = 0; sh = 0; chg = 0;
        if (n == 0) begin
            done_c = 1; sent = 0; o = 0; t = 0;
        end else begin
            last = 1 + (n - 1) * (GAP + 1);
            if (bev != 0) begin
                done_c = bev + 1; o = 1; t = 0;
                sent = (bev - 1) / (GAP + 1) + 1;
                if (sent > n) sent = n;
            end else begin
                done_c = last + TMO + 1; o = 0; t = 1; sent = n;
            end
        end
        for (int j = 0; j < sent; j++) begin
            if (hf ? (j < int'(nh)) : (j >= int'(n1))) begin
                eh[1 + j * (GAP + 1)] = 1'b1; sh++;
            end else begin
                e1[1 + j * (GAP + 1)] = 1'b1; s1++;
            end
        end
        paid = 2 * s1 + sh;
        if (paid > 31) paid = 31;
        for (int k = 1; k < done_c; k++) chg += 2 * int'(m1[k]) + int'(mh[k]);
        if (chg > 7) chg = 7;
        r = mk(o, t, paid, chg, int'(n1) - s1, int'(nh) - sh);
    endtask

    // Drives one transaction from the start cycle (cycle 0) through one
    // cycle past done, checking pulse timing every cycle against the model.
    task automatic run_txn(input bit hf, input logic [2:0] n1, input logic [2:0] nh,
                           input int bev, input logic [63:0] m1, input logic [63:0] mh,
                           input int rs, output logic [15:0] obs, output logic [15:0] mres);
        int done_c;
        logic [63:0] e1, eh;
        logic [5:0]  ev;
        model(hf, n1, nh, bev, m1, mh, done_c, mres, e1, eh);
        obs = '1;
        for (int k = 0; k <= done_c + 1; k++) begin
            @(negedge sys_clk);
            if (k >= 1) begin
                ev = {e1[k], eh[k], k < done_c, k == done_c,
                      (k >= done_c) ? mres[15] : 1'b0, (k >= done_c) ? mres[14] : 1'b0};
                chk($sformatf("cycle%0d coin/busy/done/ok/to", k),
                    64'({po_coin_one, po_coin_half, busy, done, ok, timeout}), 64'(ev));
                if (k == done_c) obs = dut_res();
            end
            start = (k == 0) || (rs != 0 && k == rs);
            if (k == 0) begin
                half_first = hf; num_one = n1; num_half = nh;
            end else if (rs != 0 && k == rs) begin
                half_first = ~hf; num_one = 3'd5; num_half = 3'd3;
            end else begin
                half_first = 1'($urandom); num_one = 3'($urandom); num_half = 3'($urandom);
            end
            pi_beverage    = (bev != 0) && (k == bev);
            pi_change_one  = m1[k];
            pi_change_half = mh[k];
        end
    endtask

    vec_t        tbl[9];
    logic [15:0] obs, mres;
    int          dones;

    initial begin
        tbl[0] = '{1'b0, 3'd2, 3'd0, 5,  64'h0,   64'h0,   0, mk(1, 0, 4, 0, 0, 0)};
        tbl[1] = '{1'b1, 3'd2, 3'd1, 8,  64'h0,   64'h100, 0, mk(1, 0, 5, 1, 0, 0)};
        tbl[2] = '{1'b0, 3'd3, 3'd0, 5,  64'h0,   64'h0,   0, mk(1, 0, 4, 0, 1, 0)};
        tbl[3] = '{1'b0, 3'd0, 3'd1, 0,  64'h0,   64'h0,   0, mk(0, 1, 1, 0, 0, 0)};
        tbl[4] = '{1'b0, 3'd0, 3'd0, 0,  64'h0,   64'h0,   0, mk(0, 0, 0, 0, 0, 0)};
        tbl[5] = '{1'b0, 3'd2, 3'd0, 5,  64'h0,   64'h0,   2, mk(1, 0, 4, 0, 0, 0)};
        tbl[6] = '{1'b0, 3'd1, 3'd2, 1,  64'h2,   64'h0,   0, mk(1, 0, 2, 2, 0, 2)};
        tbl[7] = '{1'b0, 3'd1, 3'd0, 9,  64'h200, 64'h200, 0, mk(1, 0, 2, 3, 0, 0)};
        tbl[8] = '{1'b0, 3'd7, 3'd7, 10, 64'h7FE, 64'h0,   0, mk(1, 0, 8, 7, 3, 7)};

        // Reset state
        #1;
        chk("reset_outputs", 64'(all_outs()), 64'h0);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        chk("idle_after_reset", 64'(all_outs()), 64'h0);

        // Directed vectors
        foreach (tbl[i]) begin
            run_txn(tbl[i].hf, tbl[i].n1, tbl[i].nh, tbl[i].bev, tbl[i].m1, tbl[i].mh,
                    tbl[i].rs, obs, mres);
            chk($sformatf("vec%0d result", i), 64'(obs), 64'(tbl[i].exp));
        end

        // Reset asserted in the gap after the first coin abandons the transaction
        @(negedge sys_clk);
        start = 1'b1; half_first = 1'b0; num_one = 3'd2; num_half = 3'd0;
        @(negedge sys_clk);
        start = 1'b0;
        @(negedge sys_clk);
        chk("gap_before_reset busy/paid", 64'({busy, paid_units}), 64'({1'b1, 5'd2}));
        sys_rst_n = 1'b0;
        #1;
        chk("async_reset_clear", 64'(all_outs()), 64'h0);
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge sys_clk);
            if (done || busy || po_coin_one || po_coin_half) dones++;
        end
        chk("no_activity_after_reset", 64'(dones), 64'd0);
        run_txn(1'b0, 3'd2, 3'd0, 5, 64'h0, 64'h0, 0, obs, mres);
        chk("after_reset_test1", 64'(obs), 64'(mk(1, 0, 4, 0, 0, 0)));

        // Randomised transactions against the model
        for (int t = 0; t < 40; t++) begin
            bit          hf;
            logic [2:0]  n1, nh;
            int          n, last, bev, act_end, rs;
            logic [63:0] m1, mh;
            hf = 1'($urandom_range(0, 1));
            n1 = 3'($urandom_range(0, 7));
            nh = 3'($urandom_range(0, 7));
            n  = int'(n1) + int'(nh);
            bev = 0; act_end = 0;
            if (n != 0) begin
                last = 1 + (n - 1) * (GAP + 1);
                if ($urandom_range(0, 3) != 0) bev = $urandom_range(1, last + TMO);
                act_end = (bev != 0) ? bev : last + TMO;
            end
            m1 = '0; mh = '0;
            for (int k = 1; k <= act_end; k++) begin
                m1[k] = ($urandom_range(0, 4) == 0);
                mh[k] = ($urandom_range(0, 4) == 0);
            end
            rs = (act_end != 0 && $urandom_range(0, 1) == 1) ? $urandom_range(1, act_end) : 0;
            run_txn(hf, n1, nh, bev, m1, mh, rs, obs, mres);
            chk($sformatf("rand%0d result", t), 64'(obs), 64'(mres));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
